// File: rtl/countdown_timer_pkg.sv
// Shared state encoding and default sizing for the countdown timer block.
package countdown_timer_pkg;

  localparam int DEFAULT_WIDTH = 4;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_RUN  = 2'd1,
    ST_HOLD = 2'd2,
    ST_DONE = 2'd3
  } state_e;

endpackage

// File: rtl/countdown_timer_if.sv
// Control/status bundle for countdown_timer; irq_clr/irq exist only when
// COUNTDOWN_TIMER_IRQ_EN is defined.
interface countdown_timer_if #(
    parameter int WIDTH = 4
);
    logic             load;
    logic [WIDTH-1:0] load_val;
    logic             start;
    logic             stop;
    logic             en;
    logic             auto_reload;
    logic [WIDTH-1:0] q;
    logic             tc;
    logic             busy;
`ifdef COUNTDOWN_TIMER_IRQ_EN
    logic             irq_clr;
    logic             irq;

    modport master (output load, load_val, start, stop, en, auto_reload, irq_clr,
                    input  q, tc, busy, irq);
    modport slave  (input  load, load_val, start, stop, en, auto_reload, irq_clr,
                    output q, tc, busy, irq);
`else
    modport master (output load, load_val, start, stop, en, auto_reload,
                    input  q, tc, busy);
    modport slave  (input  load, load_val, start, stop, en, auto_reload,
                    output q, tc, busy);
`endif
endinterface

// File: rtl/countdown_core.sv
// WIDTH-bit loadable decrementer with zero/one detect; load beats decrement.
module countdown_core
    import countdown_timer_pkg::*;
#(
    parameter int WIDTH = DEFAULT_WIDTH
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             ld,
    input  logic [WIDTH-1:0] ld_val,
    input  logic             dec,
    output logic [WIDTH-1:0] cnt,
    output logic             is_zero,
    output logic             is_one
);

    logic [WIDTH-1:0] cnt_q, cnt_d;

    always_comb begin
        cnt_d = cnt_q;
        if (ld) begin
            cnt_d = ld_val;
        end else if (dec) begin
            cnt_d = cnt_q - WIDTH'(1);
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

    assign cnt     = cnt_q;
    assign is_zero = (cnt_q == '0);
    assign is_one  = (cnt_q == WIDTH'(1));

endmodule

// File: rtl/countdown_timer.sv
// Loadable, pausable down-counter with terminal-count pulse and auto-reload.
// Optional sticky irq output enabled by COUNTDOWN_TIMER_IRQ_EN.
module countdown_timer
    import countdown_timer_pkg::*;
#(
    parameter int WIDTH = DEFAULT_WIDTH
) (
    input  logic               clk,
    input  logic               reset,
    countdown_timer_if.slave   bus
);

    state_e           state_q, state_d;
    logic [WIDTH-1:0] reload_q, reload_d;
    logic             tc_q, tc_d;

    logic             core_ld;
    logic [WIDTH-1:0] core_val;
    logic             core_dec;
    logic [WIDTH-1:0] cnt;
    logic             cnt_zero;
    logic             cnt_one;

    countdown_core #(.WIDTH(WIDTH)) u_core (
        .clk     (clk),
        .reset   (reset),
        .ld      (core_ld),
        .ld_val  (core_val),
        .dec     (core_dec),
        .cnt     (cnt),
        .is_zero (cnt_zero),
        .is_one  (cnt_one)
    );

    // Priority chain: load > stop > start > count. An asserted stop swallows
    // start even in states where stop itself does nothing.
    always_comb begin
        state_d  = state_q;
        reload_d = reload_q;
        tc_d     = 1'b0;
        core_ld  = 1'b0;
        core_val = reload_q;
        core_dec = 1'b0;
        if (bus.load) begin
            reload_d = bus.load_val;
            core_ld  = 1'b1;
            core_val = bus.load_val;
            state_d  = ST_IDLE;
        end else if (bus.stop) begin
            if (state_q == ST_RUN) state_d = ST_HOLD;
        end else if (bus.start && state_q != ST_RUN) begin
            case (state_q)
                ST_IDLE: if (!cnt_zero) state_d = ST_RUN;
                ST_HOLD: state_d = ST_RUN;
                ST_DONE: begin
                    if (reload_q != '0) begin
                        core_ld = 1'b1;
                        state_d = ST_RUN;
                    end
                end
                default: state_d = state_q;
            endcase
        end else if (state_q == ST_RUN && bus.en) begin
            if (cnt_one) begin
                // Expiry: reload keeps the period at reload_q ticks.
                tc_d = 1'b1;
                if (bus.auto_reload) begin
                    core_ld = 1'b1;
                end else begin
                    core_dec = 1'b1;
                    state_d  = ST_DONE;
                end
            end else begin
                core_dec = 1'b1;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q  <= ST_IDLE;
            reload_q <= '0;
            tc_q     <= 1'b0;
        end else begin
            state_q  <= state_d;
            reload_q <= reload_d;
            tc_q     <= tc_d;
        end
    end

    assign bus.q    = cnt;
    assign bus.tc   = tc_q;
    assign bus.busy = (state_q == ST_RUN) || (state_q == ST_HOLD);

`ifdef COUNTDOWN_TIMER_IRQ_EN
    logic irq_q, irq_d;

    // Set keys off tc_d so irq rises on the same edge as tc and beats a clear.
    always_comb begin
        irq_d = irq_q;
        if (tc_d) begin
            irq_d = 1'b1;
        end else if (bus.irq_clr) begin
            irq_d = 1'b0;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            irq_q <= 1'b0;
        end else begin
            irq_q <= irq_d;
        end
    end

    assign bus.irq = irq_q;
`endif

endmodule

// File: tb/tb_countdown_timer.sv
// Table-driven bench for countdown_timer: each row drives one cycle and its
// expected post-edge outputs go through a scoreboard queue.
module tb_countdown_timer;
    import countdown_timer_pkg::*;

    localparam int W = 4;

    logic clk;
    logic reset;

    countdown_timer_if #(.WIDTH(W)) bus ();

    countdown_timer #(.WIDTH(W)) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus.slave)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        string        tag;
        logic         rst;
        logic         ld;
        logic [W-1:0] lv;
        logic         st;
        logic         sp;
        logic         en;
        logic         ar;
        logic         iclr;
        logic [W-1:0] eq;
        logic         etc;
        logic         ebusy;
        logic         chk_irq;
        logic         eirq;
    } vec_t;

    vec_t vecs[$];
    vec_t sb[$];
    int   n_checks = 0;
    int   n_fail   = 0;

    function automatic vec_t mk(string tag, logic rst, logic ld, logic [W-1:0] lv,
                                logic st, logic sp, logic en, logic ar,
                                logic [W-1:0] eq, logic etc, logic eb);
        vec_t v;
        v.tag = tag; v.rst = rst; v.ld = ld; v.lv = lv; v.st = st; v.sp = sp;
        v.en = en; v.ar = ar; v.iclr = 1'b0; v.eq = eq; v.etc = etc;
        v.ebusy = eb; v.chk_irq = 1'b0; v.eirq = 1'b0;
        return v;
    endfunction

    function automatic vec_t mki(vec_t b, logic iclr, logic eirq);
        b.iclr = iclr; b.chk_irq = 1'b1; b.eirq = eirq;
        return b;
    endfunction

    task automatic check(string name, logic [31:0] act, logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    initial begin
        vec_t v, e;
        reset = 1'b1;
        bus.load = 1'b0; bus.load_val = '0; bus.start = 1'b0; bus.stop = 1'b0;
        bus.en = 1'b0; bus.auto_reload = 1'b0;
`ifdef COUNTDOWN_TIMER_IRQ_EN
        bus.irq_clr = 1'b0;
`endif
        // reset dominates toggling inputs
        vecs.push_back(mk("rst0", 1, 1, 9, 1, 0, 1, 0, 0, 0, 0));
        vecs.push_back(mk("rst1", 1, 0, 0, 1, 1, 1, 1, 0, 0, 0));
        // one-shot from 5
        vecs.push_back(mk("a_ld", 0, 1, 5, 0, 0, 0, 0, 5, 0, 0));
        vecs.push_back(mk("a_st", 0, 0, 0, 1, 0, 1, 0, 5, 0, 1));
        for (int k = 4; k >= 1; k--) vecs.push_back(mk("a_cnt", 0, 0, 0, 0, 0, 1, 0, 4'(k), 0, 1));
        vecs.push_back(mk("a_tc",   0, 0, 0, 0, 0, 1, 0, 0, 1, 0));
        vecs.push_back(mk("a_done", 0, 0, 0, 0, 0, 1, 0, 0, 0, 0));
        // auto-reload period 3
        vecs.push_back(mk("b_ld", 0, 1, 3, 0, 0, 0, 1, 3, 0, 0));
        vecs.push_back(mk("b_st", 0, 0, 0, 1, 0, 1, 1, 3, 0, 1));
        for (int r = 0; r < 3; r++) begin
            vecs.push_back(mk("b_c2", 0, 0, 0, 0, 0, 1, 1, 2, 0, 1));
            vecs.push_back(mk("b_c1", 0, 0, 0, 0, 0, 1, 1, 1, 0, 1));
            vecs.push_back(mk("b_rl", 0, 0, 0, 0, 0, 1, 1, 3, 1, 1));
        end
        // pause and resume; the load also aborts the auto-reload run
        vecs.push_back(mk("c_ld", 0, 1, 6, 0, 0, 0, 0, 6, 0, 0));
        vecs.push_back(mk("c_st", 0, 0, 0, 1, 0, 0, 0, 6, 0, 1));
        vecs.push_back(mk("c_c5", 0, 0, 0, 0, 0, 1, 0, 5, 0, 1));
        vecs.push_back(mk("c_c4", 0, 0, 0, 0, 0, 1, 0, 4, 0, 1));
        vecs.push_back(mk("c_sp", 0, 0, 0, 0, 1, 1, 0, 4, 0, 1));
        for (int k = 0; k < 5; k++) vecs.push_back(mk("c_hold", 0, 0, 0, 0, 0, 1, 0, 4, 0, 1));
        vecs.push_back(mk("c_res", 0, 0, 0, 1, 0, 1, 0, 4, 0, 1));
        for (int k = 3; k >= 1; k--) vecs.push_back(mk("c_cnt", 0, 0, 0, 0, 0, 1, 0, 4'(k), 0, 1));
        vecs.push_back(mk("c_tc",   0, 0, 0, 0, 0, 1, 0, 0, 1, 0));
        vecs.push_back(mk("c_done", 0, 0, 0, 0, 0, 1, 0, 0, 0, 0));
        // en gating
        vecs.push_back(mk("d_ld",  0, 1, 2, 0, 0, 0, 0, 2, 0, 0));
        vecs.push_back(mk("d_st",  0, 0, 0, 1, 0, 0, 0, 2, 0, 1));
        vecs.push_back(mk("d_e1",  0, 0, 0, 0, 0, 1, 0, 1, 0, 1));
        vecs.push_back(mk("d_e0",  0, 0, 0, 0, 0, 0, 0, 1, 0, 1));
        vecs.push_back(mk("d_tc",  0, 0, 0, 0, 0, 1, 0, 0, 1, 0));
        // start ignored at zero
        vecs.push_back(mk("e_ld",  0, 1, 0, 0, 0, 0, 0, 0, 0, 0));
        vecs.push_back(mk("e_st",  0, 0, 0, 1, 0, 0, 0, 0, 0, 0));
        vecs.push_back(mk("e_ste", 0, 0, 0, 1, 0, 1, 0, 0, 0, 0));
        // stop beats en on terminal cycle; restart from DONE reloads
        vecs.push_back(mk("f_ld",  0, 1, 1, 0, 0, 0, 0, 1, 0, 0));
        vecs.push_back(mk("f_st",  0, 0, 0, 1, 0, 0, 0, 1, 0, 1));
        vecs.push_back(mk("f_sp",  0, 0, 0, 0, 1, 1, 0, 1, 0, 1));
        vecs.push_back(mk("f_res", 0, 0, 0, 1, 0, 0, 0, 1, 0, 1));
        vecs.push_back(mk("f_tc",  0, 0, 0, 0, 0, 1, 0, 0, 1, 0));
        vecs.push_back(mk("f_rst", 0, 0, 0, 1, 0, 0, 0, 1, 0, 1));
        vecs.push_back(mk("f_tc2", 0, 0, 0, 0, 0, 1, 0, 0, 1, 0));
        // load beats start; reset mid-run
        vecs.push_back(mk("g_ldst", 0, 1, 4, 1, 0, 0, 0, 4, 0, 0));
        vecs.push_back(mk("g_idle", 0, 0, 0, 0, 0, 1, 0, 4, 0, 0));
        vecs.push_back(mk("g_st",   0, 0, 0, 1, 0, 1, 0, 4, 0, 1));
        vecs.push_back(mk("g_rst",  1, 0, 0, 1, 0, 1, 0, 0, 0, 0));
        // maximum reload value
        vecs.push_back(mk("h_ld", 0, 1, 15, 0, 0, 0, 0, 15, 0, 0));
        vecs.push_back(mk("h_st", 0, 0, 0, 1, 0, 0, 0, 15, 0, 1));
        for (int k = 14; k >= 1; k--) vecs.push_back(mk("h_cnt", 0, 0, 0, 0, 0, 1, 0, 4'(k), 0, 1));
        vecs.push_back(mk("h_tc", 0, 0, 0, 0, 0, 1, 0, 0, 1, 0));
        // sticky irq: set wins over same-cycle clear
        vecs.push_back(mki(mk("i_clr0", 0, 0, 0, 0, 0, 0, 0, 0, 0, 0), 1, 0));
        vecs.push_back(mki(mk("i_ld",   0, 1, 1, 0, 0, 0, 1, 1, 0, 0), 0, 0));
        vecs.push_back(mki(mk("i_st",   0, 0, 0, 1, 0, 0, 1, 1, 0, 1), 0, 0));
        vecs.push_back(mki(mk("i_tc1",  0, 0, 0, 0, 0, 1, 1, 1, 1, 1), 0, 1));
        vecs.push_back(mki(mk("i_stk",  0, 0, 0, 0, 0, 0, 1, 1, 0, 1), 0, 1));
        vecs.push_back(mki(mk("i_stk2", 0, 0, 0, 0, 0, 0, 1, 1, 0, 1), 0, 1));
        vecs.push_back(mki(mk("i_setw", 0, 0, 0, 0, 0, 1, 1, 1, 1, 1), 1, 1));
        vecs.push_back(mki(mk("i_clr",  0, 0, 0, 0, 0, 0, 1, 1, 0, 1), 1, 0));
        vecs.push_back(mki(mk("i_low",  0, 0, 0, 0, 0, 0, 1, 1, 0, 1), 0, 0));

        foreach (vecs[i]) begin
            v = vecs[i];
            reset           = v.rst;
            bus.load        = v.ld;
            bus.load_val    = v.lv;
            bus.start       = v.st;
            bus.stop        = v.sp;
            bus.en          = v.en;
            bus.auto_reload = v.ar;
`ifdef COUNTDOWN_TIMER_IRQ_EN
            bus.irq_clr     = v.iclr;
`endif
            sb.push_back(v);
            @(posedge clk);
            #1;
            e = sb.pop_front();
            check({e.tag, ".q"},    32'(bus.q),    32'(e.eq));
            check({e.tag, ".tc"},   32'(bus.tc),   32'(e.etc));
            check({e.tag, ".busy"}, 32'(bus.busy), 32'(e.ebusy));
`ifdef COUNTDOWN_TIMER_IRQ_EN
            if (e.chk_irq) check({e.tag, ".irq"}, 32'(bus.irq), 32'(e.eirq));
`endif
        end
        if (sb.size() != 0) begin
            n_checks++;
            n_fail++;
            $display("FAIL scoreboard: %0d entries left, expected 0", sb.size());
        end
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
